adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Self-checking consumer placed directly downstream of `pipelined_adder` in the adder test suites. It sees the same operands driven into the adder and computes the golden sum. It delays that sum by the adder's register depth and compares it against the adder output every cycle. It reports pass/error counts, captures the first mismatch, and asserts `done` after a fixed number of comparisons.

## Interface
- `INP_DW`, 3: operand width; sums are `INP_DW+1` bits.
- `NUM_REG`, 2: adder pipeline depth in cycles; legal range 1..8.
- `NUM_CHECKS`, 16: comparisons to perform before `done`; at least 1.
- `CNT_W`, 8: width of the pass/error counters.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `en`  in  1  checking enable, level-sensitive.
- `inp1`  in  INP_DW  operand A, same net that drives the adder.
- `inp2`  in  INP_DW  operand B, same net that drives the adder.
- `outp`  in  INP_DW+1  adder result.
- `pass_cnt`  out  CNT_W  number of matching comparisons, saturating.
- `err_cnt`  out  CNT_W  number of mismatching comparisons, saturating.
- `err_flag`  out  1  sticky; set on the first mismatch.
- `first_exp`  out  INP_DW+1  expected value at the first mismatch.
- `first_got`  out  INP_DW+1  adder output at the first mismatch.
- `done`  out  1  high once `NUM_CHECKS` comparisons have completed.

## Operation
- Golden sum: `exp = inp1 + inp2`, zero-extended to `INP_DW+1` bits; no truncation, carry kept.
- Delay line: `NUM_REG` stages, each holding {valid, expected sum}.
  - Stage 0 loads {en, exp} every cycle.
  - A compare occurs in a cycle where the last stage is valid and the FSM is in CHECK.
- FSM states: IDLE, FILL, CHECK, DONE.
  - IDLE: `en`=1 -> FILL. Counters, flag and captures are cleared on this transition.
  - FILL: counts `NUM_REG` cycles -> CHECK. No compares are made.
  - CHECK: compares each cycle. When the compare count reaches `NUM_CHECKS` -> DONE.
  - DONE: `done`=1 and all results are held. `en`=0 -> IDLE.
  - `en`=0 in FILL or CHECK -> IDLE. Valid bits are flushed; counters and captures hold their last values.
- Match: `outp == exp_delayed` increments `pass_cnt`. Otherwise `err_cnt` increments.
- First mismatch: when `err_flag` is 0, set it and load `first_exp` and `first_got`. Later mismatches do not overwrite the captures.
- Counters saturate at `2**CNT_W-1` and never wrap. The internal compare counter is sized `$clog2(NUM_CHECKS+1)`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all valid bits 0.
- Operands sampled at edge t are compared against `outp` sampled at edge t+`NUM_REG`, matching the adder latency.
- First compare happens at the edge `NUM_REG` cycles after the edge that moved the FSM IDLE -> FILL.
- Result outputs are registered and update one edge after the compare.
- `done` rises on the edge that records the `NUM_CHECKS`-th compare.
- `en` falling in the same cycle as the final compare: the compare is recorded and the FSM goes to IDLE; `done` stays 0.
- `rst` asserted mid-run: all state clears asynchronously. Operation resumes from IDLE on the first edge after `rst` returns to 1.

## Structure
- Shared package `adder_tb_pkg`: FSM state enum (`chk_state_t`) and the default localparams `DATA_WIDTH` and `NUM_REG`, shared with `tb_master`.
- One sub-module, `sum_delay_line`: parameterised depth and width shift register carrying {valid, data}. It uses the same async active-low `rst`.
- Top level holds the FSM, comparator, counters and capture registers.

## Test plan
- Reset and idle: hold `rst`=0 for 4 ns, then keep `en`=0 for 10 cycles -> all outputs stay 0 and the FSM stays in IDLE.
- Clean run (INP_DW=3, NUM_REG=2, correct adder): drive 7+7 -> compared to 14. Over 16 checks: `pass_cnt`=16, `err_cnt`=0, `done`=1 at cycle 2+16 after `en` rises.
- Injected fault: force `outp`=4'd5 for the pair 3+4 -> `err_flag`=1, `first_exp`=7, `first_got`=5. A later forced mismatch leaves the captures unchanged.
- Abort: drop `en` after 5 checks -> FSM returns to IDLE, `pass_cnt` holds 5, `done`=0. Re-raising `en` clears all counters.
- Saturation (CNT_W=2, NUM_CHECKS=6, all matching) -> `pass_cnt` sticks at 3 and `done` still rises after 6 compares.
- Mid-run reset: assert `rst`=0 during CHECK -> outputs read 0 immediately, before the next edge.

Source files
------------

// File: rtl/adder_tb_pkg.sv
// Shared definitions for the adder test suite.
// Holds the checker FSM state type and the default adder geometry, so the
// stimulus master and the result checker agree on operand width and latency.
// No ports: package only.
package adder_tb_pkg;

    localparam int DATA_WIDTH = 3;
    localparam int NUM_REG    = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        DONE
    } chk_state_t;

endpackage

// File: rtl/sum_delay_line.sv
// Shift register carrying {valid, data} through DEPTH stages.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset, clears every stage
//   flush     clears all valid bits on the next edge (data still shifts)
//   in_valid  valid bit loaded into stage 0
//   in_data   data word loaded into stage 0
//   out_valid valid bit of the last stage
//   out_data  data word of the last stage
module sum_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q,  data_d;

    // Stage 0 takes the new word, every other stage takes its predecessor.
    always_comb begin
        valid_d    = '0;
        data_d     = data_q;
        valid_d[0] = in_valid & ~flush;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1] & ~flush;
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/adder_result_checker.sv
// Self-checking consumer for pipelined_adder.
// Computes the golden sum of the operands fed to the adder, delays it by the
// adder latency and compares it with the adder output, keeping saturating
// pass/error counts and a capture of the first mismatch.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   en            level-sensitive checking enable
//   inp1, inp2    adder operands
//   outp          adder result (INP_DW+1 bits)
//   pass_cnt      matching compares, saturating
//   err_cnt       mismatching compares, saturating
//   err_flag      sticky first-mismatch flag
//   first_exp     expected value at the first mismatch
//   first_got     adder output at the first mismatch
//   done          high once NUM_CHECKS compares are complete
module adder_result_checker #(
    parameter int INP_DW     = adder_tb_pkg::DATA_WIDTH,
    parameter int NUM_REG    = adder_tb_pkg::NUM_REG,
    parameter int NUM_CHECKS = 16,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [INP_DW-1:0] inp1,
    input  logic [INP_DW-1:0] inp2,
    input  logic [INP_DW:0]   outp,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic [INP_DW:0]   first_exp,
    output logic [INP_DW:0]   first_got,
    output logic              done
);

    import adder_tb_pkg::*;

    localparam int SUM_W     = INP_DW + 1;
    localparam int CHK_W     = $clog2(NUM_CHECKS + 1);
    localparam int FILL_W    = (NUM_REG > 2) ? $clog2(NUM_REG - 1) : 1;
    localparam int FILL_LAST = (NUM_REG > 1) ? NUM_REG - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t        state_q, state_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [CHK_W-1:0]  chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_flag_q, err_flag_d;
    logic [SUM_W-1:0]  first_exp_q, first_exp_d;
    logic [SUM_W-1:0]  first_got_q, first_got_d;

    logic [SUM_W-1:0]  exp_sum;
    logic [SUM_W-1:0]  exp_dly;
    logic              exp_valid;
    logic              do_compare;

    // Carry is kept by widening before the add.
    assign exp_sum = {1'b0, inp1} + {1'b0, inp2};

    sum_delay_line #(
        .DEPTH (NUM_REG),
        .WIDTH (SUM_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (~en),
        .in_valid  (en),
        .in_data   (exp_sum),
        .out_valid (exp_valid),
        .out_data  (exp_dly)
    );

    assign do_compare = exp_valid && (state_q == CHECK);

    // FILL lasts long enough that CHECK is active in the cycle where the
    // operands sampled on the IDLE->FILL edge reach the end of the delay
    // line. With a single stage there is nothing to fill, so CHECK is
    // entered directly. Dropping en wins over the final-compare DONE move.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    if (NUM_REG == 1) begin
                        state_d = CHECK;
                    end else begin
                        state_d = FILL;
                    end
                    fill_cnt_d  = '0;
                    chk_cnt_d   = '0;
                    pass_cnt_d  = '0;
                    err_cnt_d   = '0;
                    err_flag_d  = 1'b0;
                    first_exp_d = '0;
                    first_got_d = '0;
                end
            end
            FILL: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (fill_cnt_q == FILL_W'(FILL_LAST)) begin
                    state_d = CHECK;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (do_compare && (chk_cnt_q == CHK_W'(NUM_CHECKS - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_compare) begin
            chk_cnt_d = chk_cnt_q + 1'b1;
            if (outp == exp_dly) begin
                if (pass_cnt_q != CNT_MAX) begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                end
            end else begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (!err_flag_q) begin
                    err_flag_d  = 1'b1;
                    first_exp_d = exp_dly;
                    first_got_d = outp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            chk_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign pass_cnt  = pass_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_flag  = err_flag_q;
    assign first_exp = first_exp_q;
    assign first_got = first_got_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: a behavioural adder pipeline feeds outp,
// an edge-counting reference model predicts every result output, a table of
// hand-summed operand pairs drives a clean run, and short hand-written
// sequences cover faults, abort, saturation and asynchronous reset.
module tb_adder_result_checker;

    localparam int LAT = 2;
    localparam int NCHK = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic       en_sat;
    logic [2:0] inp1, inp2;
    logic [3:0] outp;

    logic [7:0] pass_cnt, err_cnt;
    logic       err_flag, done;
    logic [3:0] first_exp, first_got;

    logic [1:0] s_pass_cnt, s_err_cnt;
    logic       s_err_flag, s_done;
    logic [3:0] s_first_exp, s_first_got;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural adder pipeline (entry 0 is what outp shows now)
    int adder_pipe[$];

    // reference model state
    int exp_hist[$];
    bit m_running, m_done, m_flag;
    int m_start, m_cmp, m_pass, m_err, m_fexp, m_fgot;

    typedef struct {
        int a;
        int b;
        int sum;
    } vec_t;
    vec_t tbl[NCHK];

    adder_result_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .inp1      (inp1),
        .inp2      (inp2),
        .outp      (outp),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .first_exp (first_exp),
        .first_got (first_got),
        .done      (done)
    );

    adder_result_checker #(
        .INP_DW     (3),
        .NUM_REG    (2),
        .NUM_CHECKS (6),
        .CNT_W      (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en_sat),
        .inp1      (inp1),
        .inp2      (inp2),
        .outp      (outp),
        .pass_cnt  (s_pass_cnt),
        .err_cnt   (s_err_cnt),
        .err_flag  (s_err_flag),
        .first_exp (s_first_exp),
        .first_got (s_first_got),
        .done      (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_running = 0; m_done = 0; m_flag = 0;
        m_start = 0; m_cmp = 0; m_pass = 0; m_err = 0; m_fexp = 0; m_fgot = 0;
    endtask

    // One rising edge as seen by the checker rules: a run starts on an edge
    // with en high from idle, compares begin LAT edges after that, and stop
    // on abort (en low) or after NCHK compares.
    task automatic modelEdge(input bit en_v, input int sum_v, input int outp_v);
        int n;
        int e;
        n = exp_hist.size();
        if (m_running) begin
            if (n - m_start >= LAT) begin
                e = exp_hist[n - LAT];
                m_cmp++;
                if (outp_v == e) begin
                    if (m_pass < 255) m_pass++;
                end else begin
                    if (m_err < 255) m_err++;
                    if (!m_flag) begin
                        m_flag = 1; m_fexp = e; m_fgot = outp_v;
                    end
                end
            end
            if (!en_v) m_running = 0;
            else if (m_cmp == NCHK) begin
                m_running = 0; m_done = 1;
            end
        end else if (m_done) begin
            if (!en_v) m_done = 0;
        end else if (en_v) begin
            m_running = 1; m_start = n; m_cmp = 0;
            m_pass = 0; m_err = 0; m_flag = 0; m_fexp = 0; m_fgot = 0;
        end
        exp_hist.push_back(sum_v);
    endtask

    task automatic checkModel();
        checkOutput("pass_cnt", int'(pass_cnt), m_pass);
        checkOutput("err_cnt", int'(err_cnt), m_err);
        checkOutput("err_flag", int'(err_flag), int'(m_flag));
        checkOutput("first_exp", int'(first_exp), m_fexp);
        checkOutput("first_got", int'(first_got), m_fgot);
        checkOutput("done", int'(done), int'(m_done));
    endtask

    // Drive one cycle: operands, enable and the adder output, then clock.
    // When corrupt is set, the adder result for this operand pair is
    // replaced by bad_val when it emerges LAT cycles later.
    task automatic applyStimulus(input bit en_v, input int a, input int b,
                                 input bit corrupt, input int bad_val);
        int o;
        en   = en_v;
        inp1 = 3'(a);
        inp2 = 3'(b);
        o    = adder_pipe[0];
        outp = 4'(o);
        @(posedge clk);
        void'(adder_pipe.pop_front());
        adder_pipe.push_back(corrupt ? bad_val : a + b);
        modelEdge(en_v, a + b, o);
        #1;
        checkModel();
    endtask

    initial begin
        int a, b;
        bit ev, cor;

        tbl[0]  = '{7, 7, 14}; tbl[1]  = '{0, 0, 0};  tbl[2]  = '{7, 0, 7};  tbl[3]  = '{0, 7, 7};
        tbl[4]  = '{4, 4, 8};  tbl[5]  = '{3, 4, 7};  tbl[6]  = '{1, 6, 7};  tbl[7]  = '{5, 5, 10};
        tbl[8]  = '{6, 7, 13}; tbl[9]  = '{2, 3, 5};  tbl[10] = '{7, 1, 8};  tbl[11] = '{1, 1, 2};
        tbl[12] = '{6, 6, 12}; tbl[13] = '{3, 3, 6};  tbl[14] = '{5, 2, 7};  tbl[15] = '{4, 3, 7};

        for (int i = 0; i < LAT; i++) adder_pipe.push_back(0);
        modelReset();
        rst = 1'b0; en = 1'b0; en_sat = 1'b0; inp1 = '0; inp2 = '0; outp = '0;

        // reset and idle
        #2;
        checkOutput("reset_pass", int'(pass_cnt), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_flag", int'(err_flag), 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(0, i % 8, 7 - (i % 8), 0, 0);
        checkOutput("idle_pass", int'(pass_cnt), 0);
        checkOutput("idle_done", int'(done), 0);

        // clean run from the table; the adder output is the hand-written sum
        $display("[TB] clean table run");
        for (int j = 0; j < NCHK + LAT; j++) begin
            int k;
            k = (j < NCHK) ? j : 0;
            applyStimulus(1, tbl[k].a, tbl[k].b, 1, tbl[k].sum);
            if (j >= LAT) begin
                checkOutput("table_pass", int'(pass_cnt), j - LAT + 1);
                checkOutput("table_err", int'(err_cnt), 0);
            end
        end
        checkOutput("table_done", int'(done), 1);
        checkOutput("table_total", int'(pass_cnt), NCHK);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("table_done_cleared", int'(done), 0);

        // injected faults
        $display("[TB] fault injection");
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 3, 4, 1, 5);
        applyStimulus(1, 2, 2, 0, 0);
        applyStimulus(1, 6, 1, 1, 0);
        checkOutput("fault_flag", int'(err_flag), 1);
        checkOutput("fault_first_exp", int'(first_exp), 7);
        checkOutput("fault_first_got", int'(first_got), 5);
        checkOutput("fault_err1", int'(err_cnt), 1);
        applyStimulus(1, 1, 2, 0, 0);
        applyStimulus(1, 1, 2, 0, 0);
        checkOutput("fault_err2", int'(err_cnt), 2);
        checkOutput("fault_keep_exp", int'(first_exp), 7);
        checkOutput("fault_keep_got", int'(first_got), 5);
        applyStimulus(0, 0, 0, 0, 0);

        // abort after five compares
        $display("[TB] abort");
        for (int i = 0; i < 6; i++) applyStimulus(1, i, 7 - i, 0, 0);
        applyStimulus(0, 2, 2, 0, 0);
        checkOutput("abort_pass", int'(pass_cnt), 5);
        checkOutput("abort_done", int'(done), 0);
        applyStimulus(0, 2, 2, 0, 0);
        checkOutput("abort_hold", int'(pass_cnt), 5);
        applyStimulus(1, 2, 2, 0, 0);
        checkOutput("restart_pass", int'(pass_cnt), 0);
        checkOutput("restart_err", int'(err_cnt), 0);
        applyStimulus(0, 0, 0, 0, 0);

        // saturation on the narrow-counter instance
        $display("[TB] saturation");
        en_sat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
            if (i == 4) checkOutput("sat_pass_at3", int'(s_pass_cnt), 3);
            if (i == 6) begin
                checkOutput("sat_pass_stuck", int'(s_pass_cnt), 3);
                checkOutput("sat_done_early", int'(s_done), 0);
            end
        end
        checkOutput("sat_done", int'(s_done), 1);
        checkOutput("sat_pass_final", int'(s_pass_cnt), 3);
        checkOutput("sat_err", int'(s_err_cnt), 0);
        en_sat = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat_done_cleared", int'(s_done), 0);

        // asynchronous reset in the middle of CHECK
        $display("[TB] mid-run reset");
        for (int i = 0; i < 8; i++) applyStimulus(1, i, i, (i == 3), 15);
        rst = 1'b0;
        #2;
        checkOutput("async_pass", int'(pass_cnt), 0);
        checkOutput("async_err", int'(err_cnt), 0);
        checkOutput("async_flag", int'(err_flag), 0);
        checkOutput("async_first_exp", int'(first_exp), 0);
        checkOutput("async_first_got", int'(first_got), 0);
        checkOutput("async_done", int'(done), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        modelReset();

        // randomized traffic against the reference model
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            a   = $urandom_range(0, 7);
            b   = $urandom_range(0, 7);
            ev  = ($urandom_range(0, 15) != 0);
            cor = ($urandom_range(0, 7) == 0);
            applyStimulus(ev, a, b, cor, $urandom_range(0, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
